register_file_16x16: RTL and testbench

REGISTER_FILE_16X16 -- requirements
Module: register_file_16x16

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_mux.sv | 27 ++
 rtl/register_file_16x16.sv | 74 +++++++
 tb/tb_register_file_16x16.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared default dimensions for the 16x16 register file and its
//             read-port multiplexers.
//  Contents : c_DATA_W - default register width in bits
//             c_ADDR_W - default address width in bits
//             c_DEPTH  - default register count (always 2**c_ADDR_W)
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int c_DATA_W = 16;
   localparam int c_ADDR_W = 4;
   localparam int c_DEPTH  = 2 ** c_ADDR_W;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_mux.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_mux
//  Purpose  : Purely combinational DEPTH:1 multiplexer. It selects one
//             register word from the flattened storage array. Because DEPTH is
//             2**ADDR_W, every select value maps to a real register.
//  Ports    : i_regs [DEPTH][DATA_W] - full register array contents
//             i_sel  [ADDR_W]        - register index to read
//             o_data [DATA_W]        - selected register word
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_read_mux
   import regfile_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int ADDR_W = c_ADDR_W,
   parameter int DEPTH  = c_DEPTH
) (
   input  logic [DEPTH-1:0][DATA_W-1:0] i_regs,
   input  logic [ADDR_W-1:0]            i_sel,
   output logic [DATA_W-1:0]            o_data
);

   assign o_data = i_regs[i_sel];

endmodule : regfile_read_mux
`default_nettype wire

// File: rtl/register_file_16x16.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_16x16
//  Purpose  : DEPTH x DATA_W register file with one synchronous write port and
//             two combinational, zero-latency read ports. Synchronous
//             active-high reset clears every register and overrides a write in
//             the same cycle. A write does not bypass to the read ports. A read
//             of the register being written returns the old contents until the
//             edge.
//  Ports    : clk    - clock, all state changes on its rising edge
//             rst    - synchronous active-high reset
//             we     - write enable
//             waddr  - write address
//             wdata  - write data
//             raddr1 - read address, port 1
//             raddr2 - read address, port 2
//             rdata1 - read data, port 1
//             rdata2 - read data, port 2
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_16x16
   import regfile_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int DEPTH  = c_DEPTH,
   parameter int ADDR_W = c_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   // Storage array. Index 0 is an ordinary register, not a hardwired zero.
   logic [DEPTH-1:0][DATA_W-1:0] r_regs;

   // Reset is tested first, so it wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_regs <= '0;
      end else if (we) begin
         r_regs[waddr] <= wdata;
      end
   end

   // Read ports see only the registered array. As a result, a write becomes
   // visible on the read ports only after the clock edge.
   regfile_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd_mux1 (
      .i_regs (r_regs),
      .i_sel  (raddr1),
      .o_data (rdata1)
   );

   regfile_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd_mux2 (
      .i_regs (r_regs),
      .i_sel  (raddr2),
      .o_data (rdata2)
   );

endmodule : register_file_16x16
`default_nettype wire

// File: tb/tb_register_file_16x16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_16x16
//  Purpose  : Self-checking bench for register_file_16x16. Each stimulus step
//             drives the inputs just after a rising edge. When the step reads
//             back data, it pushes the hand-computed expected read data into a
//             scoreboard queue. A monitor on the falling edge pops the queue
//             and compares the entry against rdata1/rdata2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_16x16;

   localparam int c_DW = 16;
   localparam int c_AW = 4;

   logic            clk;
   logic            rst;
   logic            we;
   logic [c_AW-1:0] waddr;
   logic [c_DW-1:0] wdata;
   logic [c_AW-1:0] raddr1;
   logic [c_AW-1:0] raddr2;
   logic [c_DW-1:0] rdata1;
   logic [c_DW-1:0] rdata2;

   typedef struct {
      logic [c_DW-1:0] e1;
      logic [c_DW-1:0] e2;
      logic [c_AW-1:0] a1;
      logic [c_AW-1:0] a2;
   } exp_t;

   exp_t  q_exp[$];
   string q_name[$];
   int    n_cmp = 0;
   int    n_err = 0;

   register_file_16x16 #(
      .DATA_W (c_DW),
      .DEPTH  (16),
      .ADDR_W (c_AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: on each falling edge, consume whatever expectations are queued.
   initial begin
      forever begin
         @(negedge clk);
         while (q_exp.size() > 0) begin
            exp_t  e;
            string nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_cmp++;
            if (rdata1 !== e.e1) begin
               n_err++;
               $display("FAIL %s rdata1[a=%0d]: got %h, expected %h", nm, e.a1, rdata1, e.e1);
            end
            n_cmp++;
            if (rdata2 !== e.e2) begin
               n_err++;
               $display("FAIL %s rdata2[a=%0d]: got %h, expected %h", nm, e.a2, rdata2, e.e2);
            end
         end
      end
   end

   // One cycle of stimulus. The expected values describe the state as it is
   // after the previous edges, before the coming edge applies this step's write.
   task automatic step(input logic r, input logic w, input logic [c_AW-1:0] wa,
                       input logic [c_DW-1:0] wd, input logic [c_AW-1:0] a1,
                       input logic [c_AW-1:0] a2, input bit chk,
                       input logic [c_DW-1:0] e1, input logic [c_DW-1:0] e2,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst    = r;
      we     = w;
      waddr  = wa;
      wdata  = wd;
      raddr1 = a1;
      raddr2 = a2;
      if (chk) begin
         e.e1 = e1; e.e2 = e2; e.a1 = a1; e.a2 = a2;
         q_exp.push_back(e);
         q_name.push_back(nm);
      end
   endtask

   task automatic wr(input logic [c_AW-1:0] wa, input logic [c_DW-1:0] wd);
      step(1'b0, 1'b1, wa, wd, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0, "wr");
   endtask

   task automatic rd(input logic [c_AW-1:0] a1, input logic [c_AW-1:0] a2,
                     input logic [c_DW-1:0] e1, input logic [c_DW-1:0] e2,
                     input string nm);
      step(1'b0, 1'b0, 4'd0, 16'h0, a1, a2, 1'b1, e1, e2, nm);
   endtask

   initial begin
      // Scenario 1: a one-cycle reset that coincides with a write to register 3.
      rst = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 16'hFFFF;
      raddr1 = '0; raddr2 = '0;
      for (int i = 0; i < 16; i++)
         rd(4'(i), 4'(15 - i), 16'h0000, 16'h0000, "reset_clear");

      // Scenario 2: write registers 0 and 1, then read both.
      wr(4'd0, 16'hAAAA);
      wr(4'd1, 16'h5555);
      rd(4'd0, 4'd1, 16'hAAAA, 16'h5555, "wr_r0_r1");

      // Scenario 3: write register 2, then read registers 0, 2 and 1.
      wr(4'd2, 16'hF0F0);
      rd(4'd0, 4'd2, 16'hAAAA, 16'hF0F0, "wr_r2");
      rd(4'd1, 4'd1, 16'h5555, 16'h5555, "r1_kept_same_addr");

      // Scenario 4: we=0 for three edges must leave register 2 unchanged.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 4'd2, 16'h1234, 4'd2, 4'd2, 1'b1, 16'hF0F0, 16'hF0F0, "we0_hold");
      rd(4'd2, 4'd0, 16'hF0F0, 16'hAAAA, "we0_after");

      // Scenario 5: the old value is visible until the edge; there is no bypass.
      step(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 1'b1, 16'h0000, 16'h0000, "no_bypass_pre");
      rd(4'd5, 4'd5, 16'hBEEF, 16'hBEEF, "no_bypass_post");

      // Back-to-back writes to one address: the last write wins.
      wr(4'd7, 16'h1111);
      wr(4'd7, 16'h2222);
      rd(4'd7, 4'd5, 16'h2222, 16'hBEEF, "last_write_wins");

      // Scenario 6: fill every address, then sweep both read ports.
      for (int i = 0; i < 16; i++)
         wr(4'(i), 16'h0100 + 16'(i));
      for (int i = 0; i < 16; i++)
         rd(4'(i), 4'(15 - i), 16'h0100 + 16'(i), 16'h0100 + 16'(15 - i), "sweep");
      rd(4'd15, 4'd15, 16'h010F, 16'h010F, "addr15");

      // Mid-operation reset with a simultaneous write: reset wins and clears all.
      step(1'b1, 1'b1, 4'd4, 16'h9999, 4'd4, 4'd15, 1'b1, 16'h0104, 16'h010F, "pre_midreset");
      rd(4'd4, 4'd15, 16'h0000, 16'h0000, "midreset_clear");
      rd(4'd0, 4'd9, 16'h0000, 16'h0000, "midreset_clear2");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && q_exp.size() > 0; i++)
         @(posedge clk);
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
      end
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_register_file_16x16
`default_nettype wire
